// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared opcode, state, ALUOp and PCSrc encodings for the multi-cycle CPU
// control path and datapath.
package multicycle_ctrl_fsm_pkg;

  localparam int OP_W = 6;
  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_ADD  = 6'b000000;
  localparam opcode_t OP_SUB  = 6'b000001;
  localparam opcode_t OP_ADDI = 6'b000010;
  localparam opcode_t OP_OR   = 6'b010000;
  localparam opcode_t OP_AND  = 6'b010001;
  localparam opcode_t OP_ORI  = 6'b010010;
  localparam opcode_t OP_SLT  = 6'b100110;
  localparam opcode_t OP_SW   = 6'b110000;
  localparam opcode_t OP_LW   = 6'b110001;
  localparam opcode_t OP_BEQ  = 6'b110100;
  localparam opcode_t OP_J    = 6'b111000;
  localparam opcode_t OP_HALT = 6'b111111;

  typedef enum logic [3:0] {
    ST_IF     = 4'b0000,
    ST_ID     = 4'b0001,
    ST_EXE_LS = 4'b0010,
    ST_MEM    = 4'b0011,
    ST_WB_LD  = 4'b0100,
    ST_EXE_BR = 4'b0101,
    ST_EXE_AL = 4'b0110,
    ST_WB_AL  = 4'b0111,
    ST_HLT    = 4'b1000
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLT = 3'b010,
    ALU_OR  = 3'b011,
    ALU_AND = 3'b100
  } aluop_e;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10
  } pcsrc_e;

  function automatic logic op_defined(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLT,
      OP_SW, OP_LW, OP_BEQ, OP_J, OP_HALT: op_defined = 1'b1;
      default:                             op_defined = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_ctrl_decode.sv
// Static datapath select decoder: latched opcode -> extender, ALU B source,
// ALU operation and destination register select. Purely combinational.
module multicycle_ctrl_fsm_ctrl_decode
  import multicycle_ctrl_fsm_pkg::*;
(
  input  opcode_t    op_i,
  output logic       ext_sel_o,
  output logic       alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       reg_dst_o
);

  always_comb begin
    ext_sel_o   = 1'b0;
    alu_src_b_o = 1'b0;
    alu_op_o    = ALU_ADD;
    reg_dst_o   = 1'b0;
    case (op_i)
      OP_ADD:  reg_dst_o = 1'b1;
      OP_SUB:  begin reg_dst_o = 1'b1; alu_op_o = ALU_SUB; end
      OP_ADDI: begin ext_sel_o = 1'b1; alu_src_b_o = 1'b1; end
      OP_OR:   begin reg_dst_o = 1'b1; alu_op_o = ALU_OR; end
      OP_AND:  begin reg_dst_o = 1'b1; alu_op_o = ALU_AND; end
      // ORI is the one immediate form that zero-extends
      OP_ORI:  begin alu_src_b_o = 1'b1; alu_op_o = ALU_OR; end
      OP_SLT:  begin reg_dst_o = 1'b1; alu_op_o = ALU_SLT; end
      OP_SW,
      OP_LW:   begin ext_sel_o = 1'b1; alu_src_b_o = 1'b1; end
      OP_BEQ:  begin ext_sel_o = 1'b1; alu_op_o = ALU_SUB; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle CPU control sequencer: IF/ID/EXE/MEM/WB stepping, per-state enables,
// datapath selects, halt flag and retired-instruction counter. 2..5 cycles per instruction.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int CNTW = 32
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [OPW-1:0]  opCode,
  input  logic            zero,
  output logic            PCWre,
  output logic            IRWre,
  output logic            ExtSel,
  output logic            ALUSrcB,
  output logic [2:0]      ALUOp,
  output logic            RegDst,
  output logic            RegWre,
  output logic            DBDataSrc,
  output logic            mRD,
  output logic            mWR,
  output logic [1:0]      PCSrc,
  output logic            halted,
  output logic [CNTW-1:0] insCount,
  output logic [3:0]      state
);

  state_e          state_q;
  logic [OPW-1:0]  op_q;
  logic [CNTW-1:0] cnt_q;

  logic       pc_wre, ir_wre, reg_wre, m_rd, m_wr, db_src;
  logic [1:0] pc_src;
  logic       dec_ext, dec_srcb, dec_dst;
  logic [2:0] dec_aluop;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IF;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      if (pc_wre) cnt_q <= cnt_q + CNTW'(1);
      case (state_q)
        ST_IF: state_q <= ST_ID;
        ST_ID: begin
          op_q <= opCode;
          if (opCode == OP_HALT)                          state_q <= ST_HLT;
          else if (opCode == OP_J || !op_defined(opCode)) state_q <= ST_IF;
          else if (opCode == OP_BEQ)                      state_q <= ST_EXE_BR;
          else if (opCode == OP_LW || opCode == OP_SW)    state_q <= ST_EXE_LS;
          else                                            state_q <= ST_EXE_AL;
        end
        ST_EXE_AL: state_q <= ST_WB_AL;
        ST_EXE_BR: state_q <= ST_IF;
        ST_EXE_LS: state_q <= ST_MEM;
        ST_MEM:    state_q <= (op_q == OP_LW) ? ST_WB_LD : ST_IF;
        ST_WB_AL:  state_q <= ST_IF;
        ST_WB_LD:  state_q <= ST_IF;
        ST_HLT:    state_q <= ST_HLT;
        default:   state_q <= ST_IF;
      endcase
    end
  end

  // ID must look at the live opcode: op_q still holds the previous instruction there
  always_comb begin
    ir_wre  = 1'b0;
    pc_wre  = 1'b0;
    reg_wre = 1'b0;
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    db_src  = 1'b0;
    pc_src  = PC_SEQ;
    case (state_q)
      ST_IF: ir_wre = 1'b1;
      ST_ID: begin
        if (opCode == OP_J) begin
          pc_wre = 1'b1;
          pc_src = PC_JMP;
        end else if (!op_defined(opCode)) begin
          pc_wre = 1'b1;
        end
      end
      ST_EXE_BR: begin
        pc_wre = 1'b1;
        if (zero) pc_src = PC_BR;
      end
      ST_MEM: begin
        m_rd   = (op_q == OP_LW);
        m_wr   = (op_q == OP_SW);
        pc_wre = (op_q == OP_SW);
      end
      ST_WB_AL: begin
        pc_wre  = 1'b1;
        reg_wre = 1'b1;
      end
      ST_WB_LD: begin
        pc_wre  = 1'b1;
        reg_wre = 1'b1;
        db_src  = 1'b1;
      end
      default: ;
    endcase
  end

  multicycle_ctrl_fsm_ctrl_decode u_decode (
    .op_i        (op_q),
    .ext_sel_o   (dec_ext),
    .alu_src_b_o (dec_srcb),
    .alu_op_o    (dec_aluop),
    .reg_dst_o   (dec_dst)
  );

  // Reset squashes every output immediately, not just from the next edge
  assign PCWre     = !Reset && pc_wre;
  assign IRWre     = !Reset && ir_wre;
  assign RegWre    = !Reset && reg_wre;
  assign mRD       = !Reset && m_rd;
  assign mWR       = !Reset && m_wr;
  assign DBDataSrc = !Reset && db_src;
  assign PCSrc     = Reset ? 2'b00 : pc_src;
  assign ExtSel    = !Reset && dec_ext;
  assign ALUSrcB   = !Reset && dec_srcb;
  assign RegDst    = !Reset && dec_dst;
  assign ALUOp     = Reset ? 3'b000 : dec_aluop;
  assign halted    = !Reset && (state_q == ST_HLT);
  assign insCount  = Reset ? '0 : cnt_q;
  assign state     = Reset ? 4'b0000 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench: the driver pushes per-cycle expectations from an
// instruction-class model; a negedge monitor pops and compares.
module tb_multicycle_ctrl_fsm;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [5:0]  opCode = 6'd0;
    logic        zero = 1'b0;
    logic        PCWre, IRWre, ExtSel, ALUSrcB, RegDst, RegWre, DBDataSrc, mRD, mWR, halted;
    logic [2:0]  ALUOp;
    logic [1:0]  PCSrc;
    logic [31:0] insCount;
    logic [3:0]  state;

    multicycle_ctrl_fsm #(.OPW(6), .CNTW(32)) dut (
        .CLK(CLK), .Reset(Reset), .opCode(opCode), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .ExtSel(ExtSel), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .RegDst(RegDst), .RegWre(RegWre), .DBDataSrc(DBDataSrc),
        .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc), .halted(halted),
        .insCount(insCount), .state(state)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]  st;
        logic        irwre, pcwre, regwre, mrd, mwr;
        logic [1:0]  pcsrc;
        logic        dbsrc, hlt;
        logic [31:0] cnt;
        logic        chk_sel, extsel, srcb;
        logic [2:0]  aluop;
        logic        regdst;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int passed = 0;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010,
                           OR_ = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010,
                           SLT = 6'b100110, SW = 6'b110000, LW = 6'b110001,
                           BEQ = 6'b110100, J = 6'b111000, HALT = 6'b111111;
    logic [5:0] known_ops [11] = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLT, SW, LW, BEQ, J};

    function automatic bit is_alu(input logic [5:0] op);
        return op inside {ADD, SUB, ADDI, OR_, AND_, ORI, SLT};
    endfunction

    function automatic bit is_known(input logic [5:0] op);
        return is_alu(op) || op inside {SW, LW, BEQ, J, HALT};
    endfunction

    function automatic int ins_len(input logic [5:0] op);
        if (is_alu(op) || op == SW) return 4;
        if (op == LW)  return 5;
        if (op == BEQ) return 3;
        return 2;
    endfunction

    function automatic logic [3:0] phase_state(input logic [5:0] op, input int pos);
        logic [3:0] alu_ph [4] = '{4'b0000, 4'b0001, 4'b0110, 4'b0111};
        logic [3:0] ls_ph  [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100};
        logic [3:0] br_ph  [3] = '{4'b0000, 4'b0001, 4'b0101};
        if (pos < 2)     return (pos == 0) ? 4'b0000 : 4'b0001;
        if (is_alu(op))  return alu_ph[pos];
        if (op == BEQ)   return br_ph[pos];
        return ls_ph[pos];
    endfunction

    function automatic logic [5:0] sel_of(input logic [5:0] op);
        case (op)
            ADD:     return {1'b0, 1'b0, 3'b000, 1'b1};
            SUB:     return {1'b0, 1'b0, 3'b001, 1'b1};
            ADDI:    return {1'b1, 1'b1, 3'b000, 1'b0};
            OR_:     return {1'b0, 1'b0, 3'b011, 1'b1};
            AND_:    return {1'b0, 1'b0, 3'b100, 1'b1};
            ORI:     return {1'b0, 1'b1, 3'b011, 1'b0};
            SLT:     return {1'b0, 1'b0, 3'b010, 1'b1};
            SW, LW:  return {1'b1, 1'b1, 3'b000, 1'b0};
            BEQ:     return {1'b1, 1'b0, 3'b001, 1'b0};
            default: return 6'b0;
        endcase
    endfunction

    function automatic exp_t model(input logic [5:0] op, input int pos, input logic z,
                                   input bit in_hlt, input int unsigned cnt);
        exp_t e;
        int len;
        e = '0;
        len = ins_len(op);
        e.cnt = cnt;
        if (in_hlt) begin
            e.st = 4'b1000;
            e.hlt = 1'b1;
            e.chk_sel = 1'b1;
            {e.extsel, e.srcb, e.aluop, e.regdst} = sel_of(HALT);
            return e;
        end
        e.st     = phase_state(op, pos);
        e.irwre  = (pos == 0);
        e.pcwre  = (pos == len - 1) && (op != HALT);
        e.regwre = e.pcwre && (is_alu(op) || op == LW);
        e.mrd    = (op == LW) && (pos == 3);
        e.mwr    = (op == SW) && (pos == 3);
        e.dbsrc  = (op == LW) && (pos == 4);
        e.pcsrc  = (op == J && pos == 1) ? 2'b10 : (op == BEQ && pos == 2 && z) ? 2'b01 : 2'b00;
        if (pos >= 2) begin
            e.chk_sel = 1'b1;
            {e.extsel, e.srcb, e.aluop, e.regdst} = sel_of(op);
        end
        return e;
    endfunction

    int unsigned m_cnt = 0;
    bit          m_hlt = 1'b0;

    task automatic drive(input bit rst, input logic [5:0] op_drv, input logic z, input exp_t e);
        @(posedge CLK);
        #1;
        Reset  = rst;
        opCode = op_drv;
        zero   = z;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 6'($urandom), 1'($urandom), '0);
        m_cnt = 0;
        m_hlt = 1'b0;
    endtask

    task automatic run_ins(input logic [5:0] op, input int zmode, input int abort_at);
        int len;
        logic z;
        logic [5:0] od;
        len = ins_len(op);
        for (int p = 0; p < len; p++) begin
            if (p == abort_at) begin
                do_reset(1);
                return;
            end
            z  = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            od = (p == 1) ? op : 6'($urandom);
            drive(1'b0, od, z, model(op, p, z, 1'b0, m_cnt));
        end
        if (op == HALT) m_hlt = 1'b1;
        else            m_cnt = m_cnt + 1;
    endtask

    task automatic idle_hlt(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 6'($urandom), 1'($urandom), model(HALT, 0, 1'b0, m_hlt, m_cnt));
    endtask

    always @(negedge CLK) begin
        exp_t e;
        exp_t a;
        if (Reset) begin
            checks++;
            if ({PCWre, IRWre, ExtSel, ALUSrcB, ALUOp, RegDst, RegWre, DBDataSrc,
                 mRD, mWR, PCSrc, halted, insCount, state} === '0)
                passed++;
            else
                $display("FAIL reset_outputs #%0d @%0t: outputs not all zero while Reset high (st=%b cnt=%0d ir=%b pc=%b h=%b)",
                         checks, $time, state, insCount, IRWre, PCWre, halted);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '0;
            a.st = state; a.irwre = IRWre; a.pcwre = PCWre; a.regwre = RegWre;
            a.mrd = mRD; a.mwr = mWR; a.pcsrc = PCSrc; a.dbsrc = DBDataSrc;
            a.hlt = halted; a.cnt = insCount; a.chk_sel = e.chk_sel;
            if (e.chk_sel) begin
                a.extsel = ExtSel; a.srcb = ALUSrcB; a.aluop = ALUOp; a.regdst = RegDst;
            end
            checks++;
            if (a === e) passed++;
            else $display("FAIL cycle_out #%0d @%0t: got st=%b ir=%b pc=%b rw=%b rd=%b wr=%b src=%b db=%b h=%b cnt=%0d sel=%b%b%b%b, expected st=%b ir=%b pc=%b rw=%b rd=%b wr=%b src=%b db=%b h=%b cnt=%0d sel=%b%b%b%b",
                          checks, $time, a.st, a.irwre, a.pcwre, a.regwre, a.mrd, a.mwr, a.pcsrc, a.dbsrc,
                          a.hlt, a.cnt, a.extsel, a.srcb, a.aluop, a.regdst,
                          e.st, e.irwre, e.pcwre, e.regwre, e.mrd, e.mwr, e.pcsrc, e.dbsrc,
                          e.hlt, e.cnt, e.extsel, e.srcb, e.aluop, e.regdst);
        end
    end

    initial begin
        logic [5:0] r;
        do_reset(3);
        run_ins(ORI, 2, -1);
        run_ins(LW, 2, -1);
        run_ins(SW, 2, -1);
        run_ins(BEQ, 1, -1);
        run_ins(BEQ, 0, -1);
        run_ins(J, 2, -1);
        run_ins(6'b101010, 2, -1);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                r = 6'($urandom);
                while (is_known(r)) r = 6'($urandom);
            end else begin
                r = known_ops[$urandom_range(0, 10)];
            end
            run_ins(r, 2, -1);
        end
        run_ins(HALT, 2, -1);
        idle_hlt(10);
        do_reset(2);
        run_ins(ADD, 2, -1);
        run_ins(ADD, 2, 2);
        run_ins(ADD, 2, -1);
        run_ins(HALT, 2, -1);
        idle_hlt(3);
        do_reset(1);
        run_ins(SUB, 2, -1);
        @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain #%0d @%0t: %0d expectations never compared (wait expired)",
                      checks, $time, exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
